// File: rtl/press_pkg.sv
// Shared types and helpers for the button-press round controller.
package press_pkg;

    localparam int unsigned BTN_W = 3;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned IND_W = 10;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StArm,
        StCollect,
        StLatch,
        StDone
    } state_e;

    // Index of the lowest set bit; bit 0 has the highest priority.
    function automatic logic [SEL_W-1:0] lowest_set(input logic [BTN_W-1:0] btn);
        logic [SEL_W-1:0] sel;
        sel = '0;
        for (int i = BTN_W - 1; i >= 0; i--) begin
            if (btn[i]) sel = SEL_W'(i);
        end
        return sel;
    endfunction

endpackage

// File: rtl/press_detect.sv
// Button press edge detector: a press is buttons leaving 000 while enabled.
// Registers the increment command (strobe, index, weight) one cycle after detection.
module press_detect
    import press_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [BTN_W-1:0] buttons_i,
    input  logic [2:0]       equalizer_i,
    output logic             press_o,
    output logic             valid_o,
    output logic [SEL_W-1:0] sel_o,
    output logic [2:0]       weight_o
);

    logic [BTN_W-1:0] btn_prev_q, btn_prev_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [2:0]       weight_q, weight_d;

    // History tracks regardless of enable so a held button never counts later.
    assign press_o = en_i && (buttons_i != '0) && (btn_prev_q == '0);

    always_comb begin
        btn_prev_d = buttons_i;
        valid_d    = press_o;
        sel_d      = sel_q;
        weight_d   = weight_q;
        if (press_o) begin
            sel_d    = lowest_set(buttons_i);
            weight_d = equalizer_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_prev_q <= '0;
            valid_q    <= 1'b0;
            sel_q      <= '0;
            weight_q   <= '0;
        end else begin
            btn_prev_q <= btn_prev_d;
            valid_q    <= valid_d;
            sel_q      <= sel_d;
            weight_q   <= weight_d;
        end
    end

    assign valid_o  = valid_q;
    assign sel_o    = sel_q;
    assign weight_o = weight_q;

endmodule

// File: rtl/press_round_controller.sv
// Round sequencer: clear, settle, collect bounded presses with an idle timeout,
// then latch the result and hold it until the activator drops.
module press_round_controller
    import press_pkg::*;
#(
    parameter int unsigned PRESSES       = 5,
    parameter int unsigned ARM_CYCLES    = 8,
    parameter int unsigned WINDOW_CYCLES = 1000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             activator_i,
    input  logic [BTN_W-1:0] buttons_i,
    input  logic [2:0]       equalizer_i,
    output logic             clr_o,
    output logic             inc_valid_o,
    output logic [SEL_W-1:0] inc_sel_o,
    output logic [2:0]       inc_weight_o,
    output logic             latch_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [3:0]       press_cnt_o,
    output logic [IND_W-1:0] progress_o
);

    localparam int unsigned ArmW = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam int unsigned TmrW = $clog2(WINDOW_CYCLES);
    localparam logic [ArmW-1:0] ArmLast = ArmW'(ARM_CYCLES - 1);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(WINDOW_CYCLES - 1);
    localparam logic [3:0]      CntMax  = 4'(PRESSES);

    state_e          state_q, state_d;
    logic            act_prev_q;
    logic            act_low_seen_q;
    logic [ArmW-1:0] arm_cnt_q, arm_cnt_d;
    logic [TmrW-1:0] timer_q, timer_d;
    logic [3:0]      press_cnt_q, press_cnt_d;
    logic            timeout_q, timeout_d;
    logic            start;
    logic            collect_en;
    logic            press;

    // A level held high through reset must drop once before it can start a round.
    assign start      = (state_q == StIdle) && activator_i && !act_prev_q && act_low_seen_q;
    assign collect_en = (state_q == StCollect) && (press_cnt_q < CntMax);

    press_detect u_press_detect (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (collect_en),
        .buttons_i   (buttons_i),
        .equalizer_i (equalizer_i),
        .press_o     (press),
        .valid_o     (inc_valid_o),
        .sel_o       (inc_sel_o),
        .weight_o    (inc_weight_o)
    );

    always_comb begin
        state_d     = state_q;
        arm_cnt_d   = arm_cnt_q;
        timer_d     = timer_q;
        press_cnt_d = press_cnt_q;
        timeout_d   = timeout_q;
        if (press) press_cnt_d = press_cnt_q + 4'd1;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StClear;
                    press_cnt_d = '0;
                    timeout_d   = 1'b0;
                end
            end
            StClear: begin
                arm_cnt_d = '0;
                state_d   = activator_i ? StArm : StIdle;
            end
            StArm: begin
                if (!activator_i) begin
                    state_d = StIdle;
                end else if (arm_cnt_q == ArmLast) begin
                    state_d = StCollect;
                    timer_d = '0;
                end else begin
                    arm_cnt_d = arm_cnt_q + ArmW'(1);
                end
            end
            StCollect: begin
                // Limit check sits on the cycle the last increment is visible.
                if (!activator_i) begin
                    state_d = StIdle;
                end else if (press_cnt_q == CntMax) begin
                    state_d = StLatch;
                end else if (press) begin
                    timer_d = '0;
                end else if (timer_q == TmrLast) begin
                    timeout_d = 1'b1;
                    state_d   = StLatch;
                end else begin
                    timer_d = timer_q + TmrW'(1);
                end
            end
            StLatch: state_d = StDone;
            StDone: begin
                if (!activator_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            act_prev_q     <= 1'b0;
            act_low_seen_q <= 1'b0;
            arm_cnt_q      <= '0;
            timer_q        <= '0;
            press_cnt_q    <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            act_prev_q     <= activator_i;
            act_low_seen_q <= act_low_seen_q | ~activator_i;
            arm_cnt_q      <= arm_cnt_d;
            timer_q        <= timer_d;
            press_cnt_q    <= press_cnt_d;
            timeout_q      <= timeout_d;
        end
    end

    assign clr_o       = (state_q == StClear);
    assign latch_o     = (state_q == StLatch);
    assign done_o      = (state_q == StDone);
    assign busy_o      = (state_q == StClear) || (state_q == StArm) ||
                         (state_q == StCollect) || (state_q == StLatch);
    assign timeout_o   = timeout_q;
    assign press_cnt_o = press_cnt_q;

    always_comb begin
        progress_o = '0;
        for (int i = 0; i < IND_W; i++) begin
            progress_o[i] = (int'(press_cnt_q) > i);
        end
    end

endmodule

// File: doc/press_round_controller.md
Name: press_round_controller

Overview:
Sequencer for the button-press counter datapath. On an activator rising edge it clears the datapath, waits a settling period, then accepts a bounded number of press events. Each accepted press is forwarded to the counter as a one-cycle increment command carrying the button index and equalizer weight. The round ends on the press limit or on an inter-press timeout; the controller then latches the result to the display path and holds it until activator drops.

Parameters:
PRESSES, 5, presses accepted per round (1..15)
ARM_CYCLES, 8, settling cycles between clear and press acceptance (>=1)
WINDOW_CYCLES, 1000, maximum idle cycles between presses before timeout (>=2)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-high
activator  in  1  round enable (level); rising edge starts a round, low aborts or ends it
buttons  in  3  debounced button levels
equalizer  in  3  weight code, sampled together with the press
clr  out  1  one-cycle datapath clear pulse
inc_valid  out  1  one-cycle increment command
inc_sel  out  2  index of the pressed button (0..2); valid with inc_valid
inc_weight  out  3  equalizer value sampled at the press; valid with inc_valid
latch  out  1  one-cycle pulse: datapath result to display register
busy  out  1  high in CLEAR, ARM, COLLECT and LATCH
done  out  1  high in DONE
timeout  out  1  round ended by timeout; held until the next clr
press_cnt  out  4  presses accepted in the current round
progress  out  10  thermometer of press_cnt; bit i = (press_cnt > i)

Behaviour:
- Reset (synchronous): state IDLE. All outputs 0. Activator and button history registers 0. Timer 0.
- Activator edge: act_prev is a register. A start is activator=1 with act_prev=0, detected only in IDLE.
- States and transitions:
  IDLE -> CLEAR on a start.
  CLEAR: exactly 1 cycle. clr=1; press_cnt and timeout cleared. Then ARM.
  ARM: ARM_CYCLES cycles. Buttons ignored, but btn_prev keeps tracking. Then COLLECT with the timer at 0.
  COLLECT: a press is buttons!=0 with btn_prev==0.
  LATCH: 1 cycle. latch=1. Then DONE.
  DONE: done=1; press_cnt, timeout and progress hold. DONE -> IDLE when activator=0.
- Press handling:
  - A press registers inc_valid=1 on the next cycle.
  - inc_sel is the lowest set bit of buttons (bit0 has highest priority). One increment per press, even if several bits are set.
  - inc_weight is the equalizer value in the detection cycle.
  - press_cnt increments in the same cycle inc_valid rises.
  - The timer resets to 0 on a press.
- Holding or adding buttons without returning to 000 produces no new press.
- A button already held when COLLECT starts does not count until it is released to 000.
- Press limit: when press_cnt reaches PRESSES, go to LATCH on the cycle after the last inc_valid. Further presses in that cycle are ignored.
- Timeout: the timer counts COLLECT cycles with no press. At WINDOW_CYCLES-1, set timeout=1 and go to LATCH.
  - Press and timeout in the same cycle: the press wins and the timer restarts.
- Abort: activator=0 in CLEAR, ARM or COLLECT -> IDLE next cycle.
  - No latch pulse. A pending inc_valid still issues. press_cnt holds.
- Activator held high through DONE: no restart. A new round needs a low-then-high transition.
- Only one of clr, inc_valid and latch may be high in any cycle.
- Timer width: clog2(WINDOW_CYCLES). It saturates and never wraps.

Decomposition:
- Shared package press_pkg:
  - state encoding (IDLE, CLEAR, ARM, COLLECT, LATCH, DONE)
  - BTN_W=3, SEL_W=2, IND_W=10
  - the lowest-set-bit priority function
- One natural sub-module, press_detect: registers btn_prev and outputs the press strobe, selected index and sampled weight.

Test Plan:
- Reset, then start and 3 separate presses (001, 010, 100; equalizer 5, 3, 7) -> clr 1 cycle, then 8-cycle ARM, then inc_sel/inc_weight = 0/5, 1/3, 2/7. press_cnt=3, progress=0000000111, no latch yet.
- 5 presses with buttons=110, equalizer=2 -> each gives inc_sel=1, inc_weight=2. latch 1 cycle after the 5th inc_valid, then done=1, timeout=0, progress=0000011111.
- Start and 2 presses, then idle for 1000 cycles -> timeout=1, latch pulse, press_cnt=2, done=1. Drop activator -> IDLE, busy=0.
- Hold buttons=001 across ARM into COLLECT, then 011, then 000, then 010 -> exactly 1 increment with inc_sel=1.
- Drop activator mid-COLLECT after 1 press -> IDLE next cycle, no latch, done=0. Re-raise -> clr pulse and press_cnt=0.
- Assert rst during COLLECT -> all outputs 0 next cycle. Activator held high after rst does not start a round until it goes low then high.
